// File: rtl/fx2_cmd_responder.sv
// fx2_cmd_responder
//   Device-side responder for the host register-command protocol carried
//   over the FX2 slave FIFOs. Parses the 8-byte frame
//     SYNC, wr, addr[7:0], addr[15:8], val[7:0], val[15:8], val[23:16], val[31:24]
//   from the OUT byte stream, issues one register-bus transaction, and
//   returns the 4-byte little-endian register value on the IN byte stream.
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   in_data/in_valid/in_ready     command byte stream (from OUT FIFO)
//   out_data/out_valid/out_ready  reply byte stream (to IN FIFO)
//   reg_addr/reg_wdata       register bus address / write value
//   reg_wr/reg_rd            one-cycle write / read strobes
//   reg_rdata/reg_ack        register value and completion
//   busy                     high whenever a frame is in progress
//
// Optional: define CMD_RESPONDER_STATS_EN to add saturating counters
//   stat_drop (bytes discarded while hunting), stat_abort (bad flag byte),
//   stat_timeout (bus timeouts).
module fx2_cmd_responder #(
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_VALUE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy
`ifdef CMD_RESPONDER_STATS_EN
  ,
  output logic [15:0] stat_drop,
  output logic [7:0]  stat_abort,
  output logic [7:0]  stat_timeout
`endif
);

  typedef enum logic [2:0] {HUNT, HDR, ISSUE, WAIT, REPLY} state_t;

  // Abort fires on the WAIT cycle whose count reaches TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;      // header byte index, then reply byte index
  logic        wr_q, wr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;  // remaining reply bytes, current one in [7:0]
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;

  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    unique case (state_q)
      HUNT: if (in_fire && in_data == SYNC_BYTE) begin
        state_d = HDR;
        idx_d   = 3'd1;
      end
      HDR: if (in_fire) begin
        idx_d = idx_q + 3'd1;
        // Address and value arrive LSB first, so shift each new byte in at the top.
        case (idx_q)
          3'd1:       if (in_data[7:1] != 7'd0) state_d = HUNT;
                      else                      wr_d    = in_data[0];
          3'd2, 3'd3: reg_addr_d  = {in_data, reg_addr_q[15:8]};
          default:    reg_wdata_d = {in_data, reg_wdata_q[31:8]};
        endcase
        if (idx_q == 3'd7) begin
          state_d  = ISSUE;
          reg_wr_d = wr_q;
          reg_rd_d = ~wr_q;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = 8'd0;
      end
      WAIT: begin
        if (reg_ack || tmo_q == TMO_LAST) begin
          rdata_d     = reg_ack ? reg_rdata : ERR_VALUE;
          state_d     = REPLY;
          idx_d       = 3'd0;
          out_valid_d = 1'b1;
          out_data_d  = rdata_d[7:0];
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      REPLY: if (out_fire) begin
        if (idx_q == 3'd3) begin
          state_d     = HUNT;
          out_valid_d = 1'b0;
          out_data_d  = 8'h00;
        end else begin
          idx_d      = idx_q + 3'd1;
          rdata_d    = {8'h00, rdata_q[31:8]};
          out_data_d = rdata_q[15:8];
        end
      end
      default: state_d = HUNT;
    endcase
    in_ready_d = (state_d == HUNT) || (state_d == HDR);
    busy_d     = (state_d != HUNT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      idx_q       <= 3'd0;
      wr_q        <= 1'b0;
      tmo_q       <= 8'd0;
      rdata_q     <= 32'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      reg_addr_q  <= 16'd0;
      reg_wdata_q <= 32'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;

`ifdef CMD_RESPONDER_STATS_EN
  logic [15:0] stat_drop_q, stat_drop_d;
  logic [7:0]  stat_abort_q, stat_abort_d;
  logic [7:0]  stat_timeout_q, stat_timeout_d;
  logic        drop_ev, abort_ev, tmo_ev;

  assign drop_ev  = (state_q == HUNT) && in_fire && (in_data != SYNC_BYTE);
  assign abort_ev = (state_q == HDR) && in_fire && (idx_q == 3'd1) && (in_data[7:1] != 7'd0);
  assign tmo_ev   = (state_q == WAIT) && !reg_ack && (tmo_q == TMO_LAST);

  // Saturating: stick at all-ones rather than wrap.
  always_comb begin
    stat_drop_d    = stat_drop_q    + 16'(drop_ev  && (stat_drop_q    != '1));
    stat_abort_d   = stat_abort_q   + 8'(abort_ev  && (stat_abort_q   != '1));
    stat_timeout_d = stat_timeout_q + 8'(tmo_ev    && (stat_timeout_q != '1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_drop_q    <= 16'd0;
      stat_abort_q   <= 8'd0;
      stat_timeout_q <= 8'd0;
    end else begin
      stat_drop_q    <= stat_drop_d;
      stat_abort_q   <= stat_abort_d;
      stat_timeout_q <= stat_timeout_d;
    end
  end

  assign stat_drop    = stat_drop_q;
  assign stat_abort   = stat_abort_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_fx2_cmd_responder.sv
// Bench for fx2_cmd_responder: directed and randomized frames against a
// behavioural register-file model; checks strobes, latency, reply bytes,
// back-pressure, timeout, bad-flag abort and mid-frame/mid-reply reset.
module tb_fx2_cmd_responder;
  localparam int          TIMEOUT    = 255;
  localparam logic [15:0] NOACK_ADDR = 16'h0028;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [31:0] reg_rdata = 32'd0;
  logic        resp_ack = 1'b0, spur_ack = 1'b0;
  logic        reg_ack;
  logic        busy;
`ifdef CMD_RESPONDER_STATS_EN
  logic [15:0] stat_drop;
  logic [7:0]  stat_abort, stat_timeout;
`endif

  assign reg_ack = resp_ack | spur_ack;

  always #5 clk = ~clk;

  fx2_cmd_responder dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy)
`ifdef CMD_RESPONDER_STATS_EN
    , .stat_drop(stat_drop), .stat_abort(stat_abort), .stat_timeout(stat_timeout)
`endif
  );

  int total = 0, bad = 0;
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0;
  int ack_dly = 1, ack_cyc = 0;
  int drop_m = 0, abort_m = 0, tmo_m = 0;
  logic [31:0] mem [logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: each high sample is one strobe cycle.
  always @(negedge clk) begin
    if (reg_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    if (reg_wr === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  function automatic logic [31:0] rf(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'h5A00, a};
  endfunction

  // Register-file model: writes store, both kinds return the current value
  // ack_dly cycles after the strobe; NOACK_ADDR never answers.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (reg_rd === 1'b1 || reg_wr === 1'b1) begin
        a = reg_addr;
        if (reg_wr === 1'b1) mem[a] = reg_wdata;
        if (a != NOACK_ADDR) begin
          repeat (ack_dly) @(negedge clk);
          resp_ack  = 1'b1;
          reg_rdata = rf(a);
          ack_cyc   = cyc;
          @(negedge clk);
          resp_ack  = 1'b0;
          reg_rdata = $urandom;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_stats();
`ifdef CMD_RESPONDER_STATS_EN
    chk("stat_drop", 32'(stat_drop), 32'(drop_m));
    chk("stat_abort", 32'(stat_abort), 32'(abort_m));
    chk("stat_timeout", 32'(stat_timeout), 32'(tmo_m));
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (in_ready !== 1'b1 && g < 400) begin tick(1); g++; end
    chk("in_ready_wait", 32'(g < 400), 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hAA) g = 8'h00;
      send_byte(g);
      drop_m++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_strobes"}, 32'({reg_wr, reg_rd}), 32'd0);
    chk({tag, "_addr"}, 32'(reg_addr), 32'd0);
    chk({tag, "_wdata"}, reg_wdata, 32'd0);
  endtask

  // One full transaction with expected reply from the register-file model.
  task automatic do_txn(input bit wr, input logic [15:0] a, input logic [31:0] v,
                        input int dly, input int bp_cyc);
    logic [63:0] f;
    logic [31:0] exp;
    int s, w, rd0, wr0, stall;
    bit noack;
    noack = (a == NOACK_ADDR);
    exp   = noack ? 32'hFFFF_FFFF : (wr ? v : rf(a));
    f     = {v, a, 7'd0, wr, 8'hAA};
    rd0 = rd_cnt; wr0 = wr_cnt; ack_dly = dly;
    for (int i = 0; i < 8; i++) send_byte(f[8*i +: 8]);
    s = cyc;
    chk("strobe_wr", 32'(reg_wr), 32'(wr));
    chk("strobe_rd", 32'(reg_rd), 32'(!wr));
    chk("issue_addr", 32'(reg_addr), 32'(a));
    if (wr) chk("issue_wdata", reg_wdata, v);
    chk("issue_in_ready", 32'(in_ready), 32'd0);
    chk("issue_busy", 32'(busy), 32'd1);
    w = 0;
    while (out_valid !== 1'b1 && w < 400) begin
      tick(1); w++;
      if (w == 1) chk("strobe_one_cycle", 32'({reg_wr, reg_rd}), 32'd0);
    end
    chk("reply_seen", 32'(out_valid), 32'd1);
    if (noack) chk("timeout_latency", 32'(cyc - s), 32'(1 + TIMEOUT));
    else       chk("ack_latency", 32'(cyc - ack_cyc), 32'd1);
    for (int k = 0; k < 4; k++) begin
      stall = (k == 0) ? bp_cyc : $urandom_range(0, 2);
      out_ready = 1'b0;
      repeat (stall) begin
        tick(1);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(exp[8*k +: 8]));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      chk("reply_byte", 32'(out_data), 32'(exp[8*k +: 8]));
      chk("reply_valid", 32'(out_valid), 32'd1);
      chk("reply_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
    end
    chk("done_out_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    chk("n_rd", 32'(rd_cnt - rd0), 32'(!wr));
    chk("n_wr", 32'(wr_cnt - wr0), 32'(wr));
    if (noack) tmo_m++;
    chk_stats();
  endtask

  initial begin
    int rd0, wr0, w;
    logic [15:0] addrs [4];
    addrs = '{16'h0001, 16'h0003, 16'h0010, 16'h0022};
    mem[16'h0001] = 32'h0000_0007;

    // Reset state
    tick(3);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick(1);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk_stats();

    // Garbage resync then read of 0x0001
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    drop_m += 3;
    do_txn(1'b0, 16'h0001, 32'h0, 2, 0);

    // Write 0x0003 <= 4
    do_txn(1'b1, 16'h0003, 32'h0000_0004, 3, 0);

    // Ack outside WAIT is ignored
    spur_ack = 1'b1; tick(1); spur_ack = 1'b0; tick(3);
    chk("spur_ack_out_valid", 32'(out_valid), 32'd0);
    chk("spur_ack_busy", 32'(busy), 32'd0);

    // Timeout on unanswered read
    do_txn(1'b0, NOACK_ADDR, 32'h0, 1, 0);

    // Bad flag abort, then a normal frame
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_byte(8'hAA); send_byte(8'h05);
    abort_m++;
    for (int i = 0; i < 6; i++) send_byte(8'h11);
    drop_m += 6;
    tick(5);
    chk("abort_no_strobe", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    chk("abort_no_reply", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk_stats();
    do_txn(1'b0, 16'h0003, 32'h0, 1, 0);

    // Reply back-pressure on the first byte
    do_txn(1'b0, 16'h0010, 32'h0, 4, 20);

    // Randomized traffic
    for (int n = 0; n < 8; n++) begin
      send_garbage($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom,
             $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // Reset during header byte idx 4
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    in_valid = 1'b1; in_data = 8'h55;
    reset_n = 1'b0;
    tick(1);
    in_valid = 1'b0;
    chk_reset_vals("rst_hdr");
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk("rst_hdr_in_ready", 32'(in_ready), 32'd1);
    tick(3);
    chk("rst_hdr_no_strobe", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    drop_m = 0; abort_m = 0; tmo_m = 0;
    chk_stats();
    do_txn(1'b1, 16'h0022, 32'hDEAD_BEEF, 2, 0);

    // Reset while the second reply byte is presented
    ack_dly = 1;
    begin
      logic [63:0] f;
      f = {32'h0, 16'h0010, 8'h00, 8'hAA};
      for (int i = 0; i < 8; i++) send_byte(f[8*i +: 8]);
    end
    w = 0;
    while (out_valid !== 1'b1 && w < 50) begin tick(1); w++; end
    chk("rst_rep_seen", 32'(out_valid), 32'd1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    chk("rst_rep_byte1", 32'(out_data), 32'(rf(16'h0010) >> 8) & 32'hFF);
    rd0 = rd_cnt; wr0 = wr_cnt;
    reset_n = 1'b0;
    tick(1);
    chk_reset_vals("rst_rep");
    reset_n = 1'b1;
    tick(1);
    chk("rst_rep_in_ready", 32'(in_ready), 32'd1);
    tick(3);
    chk("rst_rep_no_strobe", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    chk("rst_rep_no_reply", 32'(out_valid), 32'd0);
    drop_m = 0; abort_m = 0; tmo_m = 0;
    do_txn(1'b0, 16'h0022, 32'h0, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
